gpio_apb_ctrl: RTL and testbench



---
 rtl/gpio_apb_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_gpio_apb_ctrl.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_apb_ctrl.sv
// gpio_apb_ctrl: sole APB3 master for a CoreGPIO instance.
//
// After reset it writes CFG_INIT to every CONFIG_n register (boot). It then
// shares the bus between an interrupt-service engine and one host command port:
//   - When INT_OR is high, IRQ (0x80) is read. A nonzero, error-free masked
//     value is reported on irq_valid/irq_status and written back to clear it.
//   - Host commands are accepted on cmd_valid/cmd_ready and answered on rsp_*.
//
// Ports:
//   PCLK, PRESET          clock, synchronous active-high reset
//   PSEL..PWDATA          APB3 master outputs (all registered)
//   PRDATA/PREADY/PSLVERR slave response
//   INT_OR                OR of the GPIO interrupts
//   cmd_*                 host request; cmd_ready is high in the IDLE cycle the
//                         host wins arbitration
//   rsp_*                 host completion pulse, read data and error flag
//   irq_valid/irq_status  pulse and held, IO_NUM-masked IRQ status
//   boot_done/boot_err    sticky boot status
module gpio_apb_ctrl #(
  parameter int unsigned IO_NUM   = 8,
  parameter logic [7:0]  CFG_INIT = 8'h05,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  input  logic        INT_OR,
  input  logic        cmd_valid,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        irq_valid,
  output logic [31:0] irq_status,
  output logic        boot_done,
  output logic        boot_err
);

  localparam logic [31:0] IrqMask  = (IO_NUM >= 32) ? 32'hFFFF_FFFF :
                                     ((32'd1 << IO_NUM) - 32'd1);
  localparam logic [5:0]  BootLast = 6'(IO_NUM - 1);
  localparam logic [15:0] TmoLast  = 16'(TIMEOUT - 1);
  localparam logic [7:0]  IrqAddr  = 8'h80;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;
  typedef enum logic [1:0] {JobBoot, JobIrqRd, JobIrqClr, JobHost} job_e;

  state_e      state_q, state_d;
  job_e        job_q, job_d;
  logic [5:0]  boot_cnt_q, boot_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [7:0]  paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        clr_pend_q, clr_pend_d;
  logic [31:0] irq_raw_q, irq_raw_d;
  // Tie-break memory: 1 when HOST won the last IRQ_RD/HOST decision.
  logic        last_host_q, last_host_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        irq_valid_q, irq_valid_d;
  logic [31:0] irq_status_q, irq_status_d;
  logic        boot_done_q, boot_done_d;
  logic        boot_err_q, boot_err_d;

  logic        start;
  logic        nxt_write;
  logic [7:0]  nxt_addr;
  logic [31:0] nxt_wdata;
  logic        done;
  logic        xfer_err;
  logic [31:0] masked;

  always_comb begin
    state_d      = state_q;
    job_d        = job_q;
    boot_cnt_d   = boot_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    clr_pend_d   = clr_pend_q;
    irq_raw_d    = irq_raw_q;
    last_host_d  = last_host_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    irq_valid_d  = 1'b0;
    irq_status_d = irq_status_q;
    boot_done_d  = boot_done_q;
    boot_err_d   = boot_err_q;
    cmd_ready    = 1'b0;
    start        = 1'b0;
    nxt_write    = 1'b0;
    nxt_addr     = 8'h00;
    nxt_wdata    = 32'h0;
    done         = 1'b0;
    xfer_err     = 1'b0;
    masked       = PRDATA & IrqMask;

    case (state_q)
      StIdle: begin
        if (!boot_done_q) begin
          start     = 1'b1;
          job_d     = JobBoot;
          nxt_write = 1'b1;
          nxt_addr  = {boot_cnt_q, 2'b00};
          nxt_wdata = {24'h0, CFG_INIT};
        end else if (clr_pend_q) begin
          start      = 1'b1;
          job_d      = JobIrqClr;
          nxt_write  = 1'b1;
          nxt_addr   = IrqAddr;
          nxt_wdata  = irq_raw_q;
          clr_pend_d = 1'b0;
        end else if (INT_OR && (!cmd_valid || last_host_q)) begin
          start       = 1'b1;
          job_d       = JobIrqRd;
          nxt_addr    = IrqAddr;
          last_host_d = 1'b0;
        end else if (cmd_valid) begin
          start       = 1'b1;
          job_d       = JobHost;
          cmd_ready   = 1'b1;
          nxt_write   = cmd_write;
          nxt_addr    = cmd_addr;
          nxt_wdata   = cmd_wdata;
          last_host_d = 1'b1;
        end
        if (start) begin
          state_d  = StSetup;
          psel_d   = 1'b1;
          pwrite_d = nxt_write;
          paddr_d  = nxt_addr;
          pwdata_d = nxt_wdata;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
        tmo_cnt_d = 16'h0;
      end
      StAccess: begin
        done     = PREADY || (tmo_cnt_q == TmoLast);
        // Only meaningful when done: either a slave error or a timeout.
        xfer_err = !PREADY || PSLVERR;
        if (done) begin
          state_d   = StIdle;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          unique case (job_q)
            JobBoot: begin
              boot_err_d = boot_err_q | xfer_err;
              if (boot_cnt_q == BootLast) begin
                boot_done_d = 1'b1;
              end else begin
                boot_cnt_d = boot_cnt_q + 6'd1;
              end
            end
            JobIrqRd: begin
              if (!xfer_err && (masked != 32'h0)) begin
                irq_valid_d  = 1'b1;
                irq_status_d = masked;
                irq_raw_d    = PRDATA;
                clr_pend_d   = 1'b1;
              end
            end
            JobIrqClr: begin
            end
            JobHost: begin
              rsp_valid_d = 1'b1;
              rsp_err_d   = xfer_err;
              rsp_rdata_d = (xfer_err || pwrite_q) ? 32'h0 : PRDATA;
            end
          endcase
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= StIdle;
      job_q        <= JobBoot;
      boot_cnt_q   <= 6'h0;
      tmo_cnt_q    <= 16'h0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= 8'h0;
      pwdata_q     <= 32'h0;
      clr_pend_q   <= 1'b0;
      irq_raw_q    <= 32'h0;
      last_host_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
      irq_valid_q  <= 1'b0;
      irq_status_q <= 32'h0;
      boot_done_q  <= 1'b0;
      boot_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      job_q        <= job_d;
      boot_cnt_q   <= boot_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      clr_pend_q   <= clr_pend_d;
      irq_raw_q    <= irq_raw_d;
      last_host_q  <= last_host_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      irq_valid_q  <= irq_valid_d;
      irq_status_q <= irq_status_d;
      boot_done_q  <= boot_done_d;
      boot_err_q   <= boot_err_d;
    end
  end

  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign irq_valid  = irq_valid_q;
  assign irq_status = irq_status_q;
  assign boot_done  = boot_done_q;
  assign boot_err   = boot_err_q;

endmodule

// File: tb/tb_gpio_apb_ctrl.sv
// Directed bench for gpio_apb_ctrl with a small APB slave model and a log of
// every SETUP phase (address, direction, data, cycle number).
module tb_gpio_apb_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        preset = 1'b1;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = 32'h0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic        int_or = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = 8'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        cmd_ready, rsp_valid, rsp_err, irq_valid, boot_done, boot_err;
  logic [31:0] rsp_rdata, irq_status;

  int n_checks = 0;
  int n_pass   = 0;

  gpio_apb_ctrl #(
    .IO_NUM  (8),
    .CFG_INIT(8'h05),
    .TIMEOUT (16)
  ) dut (
    .PCLK      (clk),
    .PRESET    (preset),
    .PSEL      (psel),
    .PENABLE   (penable),
    .PWRITE    (pwrite),
    .PADDR     (paddr),
    .PWDATA    (pwdata),
    .PRDATA    (prdata),
    .PREADY    (pready),
    .PSLVERR   (pslverr),
    .INT_OR    (int_or),
    .cmd_valid (cmd_valid),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_ready (cmd_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .irq_valid (irq_valid),
    .irq_status(irq_status),
    .boot_done (boot_done),
    .boot_err  (boot_err)
  );

  int edge_cnt = 0;
  int base = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Slave model configuration.
  int          ws_cfg = 0;
  int          ws_cnt = 0;
  bit          never_ready = 1'b0;
  bit          err_en = 1'b0;
  logic [7:0]  err_addr = 8'h0C;
  logic [31:0] irq_val = 32'h0;
  logic [31:0] other_val = 32'h0;

  logic [7:0]  log_addr[$];
  logic        log_wr[$];
  logic [31:0] log_wd[$];
  int          log_cyc[$];

  always @(negedge clk) begin
    if (psel && !penable) begin
      log_addr.push_back(paddr);
      log_wr.push_back(pwrite);
      log_wd.push_back(pwdata);
      log_cyc.push_back(edge_cnt - base);
    end
    if (psel && penable) begin
      pready = !never_ready && (ws_cnt >= ws_cfg);
      ws_cnt = ws_cnt + 1;
    end else begin
      pready = 1'b0;
      ws_cnt = 0;
    end
    prdata  = (paddr == 8'h80) ? irq_val : other_val;
    pslverr = pready && err_en && (paddr == err_addr);
  end

  function automatic int cyc();
    return edge_cnt - base;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_wr.delete();
    log_wd.delete();
    log_cyc.delete();
  endtask

  // Call right after tick() with preset high; this cycle becomes cycle 0.
  task automatic release_reset();
    preset = 1'b0;
    base   = edge_cnt;
    clear_log();
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({psel, penable, pwrite} !== 3'b000)
      $display("FAIL reset_bus_ctl: got %b want 000", {psel, penable, pwrite});
    else n_pass++;
    n_checks++;
    if ({paddr, pwdata} !== 40'h0)
      $display("FAIL reset_addr_data: got %h/%h want 0/0", paddr, pwdata);
    else n_pass++;
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_err, irq_valid, boot_done, boot_err} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000",
               {cmd_ready, rsp_valid, rsp_err, irq_valid, boot_done, boot_err});
    else n_pass++;
    n_checks++;
    if ({rsp_rdata, irq_status} !== 64'h0)
      $display("FAIL reset_data_out: got %h/%h want 0/0", rsp_rdata, irq_status);
    else n_pass++;
  endtask

  // Boot with a host read pending from cycle 0: host must wait until cycle 24.
  task automatic test_boot();
    int acc = -1;
    int done_cyc = -1;
    int rsp_cyc = -1;
    logic [31:0] rd = 32'h0;
    release_reset();
    other_val = 32'h1234_5678;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'hA0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (acc >= 0) cmd_valid = 1'b0;
      if (cmd_ready && acc < 0) acc = cyc();
      if (boot_done && done_cyc < 0) done_cyc = cyc();
      if (rsp_valid && rsp_cyc < 0) begin
        rsp_cyc = cyc();
        rd = rsp_rdata;
      end
      tick();
    end
    n_checks++;
    if (log_addr.size() !== 9)
      $display("FAIL boot_xfer_count: got %0d want 9", log_addr.size());
    else n_pass++;
    for (int k = 0; k < 8 && k < log_addr.size(); k++) begin
      n_checks++;
      if ({log_addr[k], log_wr[k], log_wd[k]} !== {8'(4 * k), 1'b1, 32'h5})
        $display("FAIL boot_write_%0d: got addr %h wr %b data %h want addr %h wr 1 data 5",
                 k, log_addr[k], log_wr[k], log_wd[k], 8'(4 * k));
      else n_pass++;
      n_checks++;
      if (log_cyc[k] !== 3 * k + 1)
        $display("FAIL boot_setup_cycle_%0d: got %0d want %0d", k, log_cyc[k], 3 * k + 1);
      else n_pass++;
    end
    n_checks++;
    if (done_cyc !== 24) $display("FAIL boot_done_cycle: got %0d want 24", done_cyc);
    else n_pass++;
    n_checks++;
    if (boot_err !== 1'b0) $display("FAIL boot_err_clean: got %b want 0", boot_err);
    else n_pass++;
    n_checks++;
    if (acc !== 24) $display("FAIL boot_host_accept_cycle: got %0d want 24", acc);
    else n_pass++;
    n_checks++;
    if (rsp_cyc !== 27 || rd !== 32'h1234_5678)
      $display("FAIL boot_host_rsp: got cycle %0d data %h want cycle 27 data 12345678",
               rsp_cyc, rd);
    else n_pass++;
  endtask

  task automatic test_irq_service();
    int c0;
    int seen = -1;
    int pulses = 0;
    logic [31:0] st = 32'h0;
    clear_log();
    irq_val = 32'h0000_0104;
    int_or  = 1'b1;
    c0 = cyc();
    for (int i = 0; i < 20; i++) begin
      #1;
      if (irq_valid) begin
        pulses++;
        if (seen < 0) begin
          seen   = cyc();
          st     = irq_status;
          int_or = 1'b0;
        end
      end
      tick();
    end
    n_checks++;
    if (seen !== c0 + 3 || st !== 32'h4)
      $display("FAIL irq_capture: got cycle %0d status %h want cycle %0d status 00000004",
               seen, st, c0 + 3);
    else n_pass++;
    n_checks++;
    if (pulses !== 1) $display("FAIL irq_pulse_count: got %0d want 1", pulses);
    else n_pass++;
    n_checks++;
    if (log_addr.size() !== 2)
      $display("FAIL irq_xfer_count: got %0d want 2", log_addr.size());
    else n_pass++;
    if (log_addr.size() >= 2) begin
      n_checks++;
      if ({log_addr[0], log_wr[0]} !== {8'h80, 1'b0} || log_cyc[0] !== c0 + 1)
        $display("FAIL irq_read: got addr %h wr %b cycle %0d want addr 80 wr 0 cycle %0d",
                 log_addr[0], log_wr[0], log_cyc[0], c0 + 1);
      else n_pass++;
      n_checks++;
      if ({log_addr[1], log_wr[1], log_wd[1]} !== {8'h80, 1'b1, 32'h104} ||
          log_cyc[1] !== c0 + 4)
        $display("FAIL irq_clear: got addr %h wr %b data %h cycle %0d want 80 1 104 cycle %0d",
                 log_addr[1], log_wr[1], log_wd[1], log_cyc[1], c0 + 4);
      else n_pass++;
    end
  endtask

  task automatic test_irq_zero();
    int pulses = 0;
    clear_log();
    irq_val = 32'h0000_0100;
    int_or  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (log_addr.size() >= 1) int_or = 1'b0;
      if (irq_valid) pulses++;
      tick();
    end
    n_checks++;
    if (pulses !== 0) $display("FAIL irq_zero_pulse: got %0d want 0", pulses);
    else n_pass++;
    n_checks++;
    if (log_addr.size() !== 1)
      $display("FAIL irq_zero_no_clear: got %0d transfers want 1", log_addr.size());
    else n_pass++;
    n_checks++;
    if (irq_status !== 32'h4) $display("FAIL irq_status_held: got %h want 00000004", irq_status);
    else n_pass++;
  endtask

  task automatic test_host_read();
    int acc = -1;
    int rsp_cyc = -1;
    int nacc = 0;
    logic [31:0] rd = 32'h0;
    logic er = 1'b1;
    logic ps = 1'b1;
    clear_log();
    ws_cfg    = 2;
    other_val = 32'h5A;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'hA0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (acc >= 0) cmd_valid = 1'b0;
      if (cmd_ready && acc < 0) acc = cyc();
      if (psel && penable) nacc++;
      if (rsp_valid && rsp_cyc < 0) begin
        rsp_cyc = cyc();
        rd = rsp_rdata;
        er = rsp_err;
        ps = psel;
      end
      tick();
    end
    ws_cfg = 0;
    n_checks++;
    if (nacc !== 3) $display("FAIL host_read_access_len: got %0d want 3", nacc);
    else n_pass++;
    n_checks++;
    if (rd !== 32'h5A || er !== 1'b0)
      $display("FAIL host_read_rsp: got data %h err %b want 0000005a err 0", rd, er);
    else n_pass++;
    n_checks++;
    if (acc < 0 || rsp_cyc !== acc + 5 || ps !== 1'b0)
      $display("FAIL host_read_timing: got accept %0d rsp %0d psel %b want rsp accept+5 psel 0",
               acc, rsp_cyc, ps);
    else n_pass++;
    n_checks++;
    if (log_addr.size() !== 1 || log_addr[0] !== 8'hA0 || log_wr[0] !== 1'b0)
      $display("FAIL host_read_bus: got %0d xfers first addr %h want 1 xfer addr a0 read",
               log_addr.size(), log_addr[0]);
    else n_pass++;
  endtask

  task automatic test_contention();
    int c0;
    int readies = 0;
    logic [7:0]  ea;
    logic        ew;
    logic [31:0] ed;
    clear_log();
    irq_val   = 32'h3;
    int_or    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h90;
    cmd_wdata = 32'hDEAD_BEEF;
    c0 = cyc();
    for (int i = 0; i < 30; i++) begin
      #1;
      if (log_addr.size() >= 6) begin
        int_or    = 1'b0;
        cmd_valid = 1'b0;
      end
      if (cmd_ready) readies++;
      tick();
    end
    n_checks++;
    if (log_addr.size() !== 6)
      $display("FAIL contention_xfer_count: got %0d want 6", log_addr.size());
    else n_pass++;
    for (int k = 0; k < 6 && k < log_addr.size(); k++) begin
      ea = (k % 3 == 2) ? 8'h90 : 8'h80;
      ew = (k % 3 != 0);
      ed = (k % 3 == 1) ? 32'h3 : ((k % 3 == 2) ? 32'hDEAD_BEEF : 32'h0);
      n_checks++;
      if ({log_addr[k], log_wr[k], (log_wr[k] ? log_wd[k] : 32'h0)} !== {ea, ew, ed} ||
          log_cyc[k] !== c0 + 1 + 3 * k)
        $display("FAIL contention_order_%0d: got %h %b %h cyc %0d want %h %b %h cyc %0d",
                 k, log_addr[k], log_wr[k], log_wd[k], log_cyc[k], ea, ew, ed, c0 + 1 + 3 * k);
      else n_pass++;
    end
    n_checks++;
    if (readies !== 2) $display("FAIL contention_host_accepts: got %0d want 2", readies);
    else n_pass++;
    n_checks++;
    if (irq_status !== 32'h3) $display("FAIL contention_irq_status: got %h want 00000003",
                                       irq_status);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int acc = -1;
    int rsp_cyc = -1;
    int nacc = 0;
    logic er = 1'b0;
    logic ps = 1'b1;
    logic [31:0] rd = 32'hFFFF_FFFF;
    never_ready = 1'b1;
    other_val   = 32'h77;
    cmd_valid   = 1'b1;
    cmd_write   = 1'b1;
    cmd_addr    = 8'h90;
    cmd_wdata   = 32'h11;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (acc >= 0) cmd_valid = 1'b0;
      if (cmd_ready && acc < 0) acc = cyc();
      if (psel && penable) nacc++;
      if (rsp_valid && rsp_cyc < 0) begin
        rsp_cyc = cyc();
        er = rsp_err;
        rd = rsp_rdata;
        ps = psel;
      end
      tick();
    end
    never_ready = 1'b0;
    n_checks++;
    if (nacc !== 16) $display("FAIL timeout_access_len: got %0d want 16", nacc);
    else n_pass++;
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0)
      $display("FAIL timeout_rsp: got err %b data %h want err 1 data 0", er, rd);
    else n_pass++;
    n_checks++;
    if (acc < 0 || rsp_cyc !== acc + 18 || ps !== 1'b0)
      $display("FAIL timeout_timing: got accept %0d rsp %0d psel %b want rsp accept+18 psel 0",
               acc, rsp_cyc, ps);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    int acc = -1;
    bit hit = 1'b0;
    int pulses = 0;
    never_ready = 1'b1;
    cmd_valid   = 1'b1;
    cmd_write   = 1'b0;
    cmd_addr    = 8'hA0;
    for (int i = 0; i < 10 && !hit; i++) begin
      #1;
      if (acc >= 0) cmd_valid = 1'b0;
      if (cmd_ready && acc < 0) acc = cyc();
      if (psel && penable) begin
        hit = 1'b1;
        preset = 1'b1;
      end
      tick();
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (!hit) $display("FAIL midreset_reach_access: got no ACCESS want ACCESS within 10 cycles");
    else n_pass++;
    n_checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, irq_valid, boot_done, boot_err} !== 8'h0 ||
        {paddr, pwdata, irq_status, rsp_rdata} !== 104'h0)
      $display("FAIL midreset_outputs: got ctl %b addr %h wdata %h irq %h rdata %h want all 0",
               {psel, penable, pwrite, rsp_valid, rsp_err, irq_valid, boot_done, boot_err},
               paddr, pwdata, irq_status, rsp_rdata);
    else n_pass++;
    never_ready = 1'b0;
    release_reset();
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rsp_valid) pulses++;
      tick();
    end
    n_checks++;
    if (pulses !== 0) $display("FAIL midreset_no_rsp: got %0d pulses want 0", pulses);
    else n_pass++;
    n_checks++;
    if (log_addr.size() < 2 || {log_addr[0], log_wr[0], log_wd[0]} !== {8'h00, 1'b1, 32'h5} ||
        log_cyc[0] !== 1 || log_addr[1] !== 8'h04 || log_cyc[1] !== 4)
      $display("FAIL midreset_boot_restart: got %0d xfers first addr %h cyc %0d want addr 00 cyc 1",
               log_addr.size(), log_addr[0], log_cyc[0]);
    else n_pass++;
  endtask

  task automatic test_boot_err();
    int done_cyc = -1;
    int err_cyc = -1;
    preset = 1'b1;
    tick();
    release_reset();
    err_en   = 1'b1;
    err_addr = 8'h0C;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (boot_done && done_cyc < 0) done_cyc = cyc();
      if (boot_err && err_cyc < 0) err_cyc = cyc();
      tick();
    end
    err_en = 1'b0;
    n_checks++;
    if (err_cyc !== 12) $display("FAIL boot_err_cycle: got %0d want 12", err_cyc);
    else n_pass++;
    n_checks++;
    if (done_cyc !== 24 || boot_err !== 1'b1)
      $display("FAIL boot_err_completes: got done cyc %0d err %b want 24 and 1",
               done_cyc, boot_err);
    else n_pass++;
    n_checks++;
    if (log_addr.size() !== 8 || log_addr[7] !== 8'h1C)
      $display("FAIL boot_err_all_writes: got %0d xfers want 8 ending at 1c", log_addr.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_irq_service();
    test_irq_zero();
    test_host_read();
    test_contention();
    test_timeout();
    test_reset_mid_access();
    test_boot_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
